// File: rtl/wbm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wbm_rr_arbiter
//
// Round-robin arbiter that shares one 16-bit Wishbone slave port between
// NUM_MASTERS masters. Requests are latched into a pending vector. While
// idle, the arbiter grants the first pending master after the one served
// last. A watchdog aborts any slave cycle that gets no ack/err within
// TIMEOUT cycles and returns err to the waiting master.
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, synchronous active-low reset
//   wbm_cyc_i/stb_i/we_i     per-master control, one bit per master
//   wbm_sel_i                per-master byte selects, 2 bits per master
//   wbm_adr_i/dat_i          per-master address / write data, 16 bits each
//   wbm_dat_o                slave read data, broadcast to all masters
//   wbm_ack_o/err_o          per-master response, only the granted bit moves
//   wbm_mask                 1 = master may post new requests
//   wbs_*                    single Wishbone slave port
//   wbm_id                   index of the granted master
//   arb_busy                 high while a slave cycle is in progress
//   timeout_cnt, timeout_id  watchdog abort count (saturating) and last victim
// ---------------------------------------------------------------------------
module wbm_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_BITS     = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [2*NUM_MASTERS-1:0]    wbm_sel_i,
    input  logic [16*NUM_MASTERS-1:0]   wbm_adr_i,
    input  logic [16*NUM_MASTERS-1:0]   wbm_dat_i,
    output logic [15:0]                 wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    input  logic [NUM_MASTERS-1:0]      wbm_mask,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic                        wbs_we_o,
    output logic [1:0]                  wbs_sel_o,
    output logic [15:0]                 wbs_adr_o,
    output logic [15:0]                 wbs_dat_o,
    input  logic [15:0]                 wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    output logic [ID_BITS-1:0]          wbm_id,
    output logic                        arb_busy,
    output logic [7:0]                  timeout_cnt,
    output logic [ID_BITS-1:0]          timeout_id
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [NUM_MASTERS-1:0] pending;
    logic [NUM_MASTERS-1:0] pending_n;
    logic [ID_BITS-1:0]     last;
    logic [15:0]            wdog;
    logic [ID_BITS-1:0]     grant;
    logic                   grant_vld;
    logic                   resp;
    logic                   wdog_hit;
    logic                   abort;
    logic                   done;

    assign resp     = wbs_ack_i | wbs_err_i;
    assign wdog_hit = (wdog == 16'(TIMEOUT - 1));
    // A slave response in the limit cycle takes precedence over the abort.
    assign abort    = (state == ACTIVE) && wdog_hit && !resp;
    assign done     = (state == ACTIVE) && (resp || wdog_hit);

    assign wbs_cyc_o = (state == ACTIVE);
    assign wbs_stb_o = wbs_cyc_o;
    assign arb_busy  = (state == ACTIVE);
    assign wbm_dat_o = wbs_dat_i;

    // Round-robin search in two passes: the lowest pending index above the
    // last-served master, otherwise the lowest pending index at or below it.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (!grant_vld && pending[m] && (ID_BITS'(m) > last)) begin
                grant     = ID_BITS'(m);
                grant_vld = 1'b1;
            end
        end
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (!grant_vld && pending[m] && (ID_BITS'(m) <= last)) begin
                grant     = ID_BITS'(m);
                grant_vld = 1'b1;
            end
        end
    end

    // The completing master's clear overrides its own same-cycle set, so a
    // still-held stb is not re-latched; other masters' sets are kept.
    always_comb begin
        pending_n = pending | (wbm_cyc_i & wbm_stb_i & wbm_mask);
        if (done) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (wbm_id == ID_BITS'(m)) begin
                    pending_n[m] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_vld) state_n = ACTIVE;
            ACTIVE:  if (done)      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            pending     <= '0;
            last        <= ID_BITS'(NUM_MASTERS - 1);
            wbm_id      <= '0;
            wdog        <= '0;
            timeout_cnt <= '0;
            timeout_id  <= '0;
        end else begin
            pending <= pending_n;
            if ((state == IDLE) && grant_vld) begin
                wbm_id <= grant;
                wdog   <= '0;
            end else if ((state == ACTIVE) && !done) begin
                wdog <= wdog + 16'd1;
            end
            if (done) begin
                last <= wbm_id;
            end
            if (abort) begin
                timeout_id <= wbm_id;
                if (timeout_cnt != 8'hFF) begin
                    timeout_cnt <= timeout_cnt + 8'd1;
                end
            end
        end
    end

    // Slave-side mux and response routing, both indexed by the granted id.
    // Responses are only forwarded in ACTIVE, so a stray ack in IDLE is dropped.
    always_comb begin
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (wbm_id == ID_BITS'(m)) begin
                wbs_we_o     = wbm_we_i[m];
                wbs_sel_o    = wbm_sel_i[2*m +: 2];
                wbs_adr_o    = wbm_adr_i[16*m +: 16];
                wbs_dat_o    = wbm_dat_i[16*m +: 16];
                wbm_ack_o[m] = (state == ACTIVE) && wbs_ack_i;
                wbm_err_o[m] = (state == ACTIVE) && (wbs_err_i || abort);
            end
        end
    end

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wbm_rr_arbiter
//
// Directed bench for wbm_rr_arbiter with four masters and a 16-cycle
// watchdog. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wbm_rr_arbiter;

    localparam int NM = 4;
    localparam int IB = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cyc, stb, we, mask;
    logic [7:0]  sel;
    logic [63:0] adr, mdat_w;
    logic [15:0] mdat_r;
    logic [3:0]  ack, err;
    logic        s_cyc, s_stb, s_we;
    logic [1:0]  s_sel;
    logic [15:0] s_adr, s_dat_w, s_dat_r;
    logic        s_ack, s_err;
    logic [1:0]  id;
    logic        busy;
    logic [7:0]  tcnt;
    logic [1:0]  tid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wbm_rr_arbiter #(.NUM_MASTERS(NM), .ID_BITS(IB), .TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbm_cyc_i   (cyc),
        .wbm_stb_i   (stb),
        .wbm_we_i    (we),
        .wbm_sel_i   (sel),
        .wbm_adr_i   (adr),
        .wbm_dat_i   (mdat_w),
        .wbm_dat_o   (mdat_r),
        .wbm_ack_o   (ack),
        .wbm_err_o   (err),
        .wbm_mask    (mask),
        .wbs_cyc_o   (s_cyc),
        .wbs_stb_o   (s_stb),
        .wbs_we_o    (s_we),
        .wbs_sel_o   (s_sel),
        .wbs_adr_o   (s_adr),
        .wbs_dat_o   (s_dat_w),
        .wbs_dat_i   (s_dat_r),
        .wbs_ack_i   (s_ack),
        .wbs_err_i   (s_err),
        .wbm_id      (id),
        .arb_busy    (busy),
        .timeout_cnt (tcnt),
        .timeout_id  (tid)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = '0; stb = '0; mask = 4'hF;
        s_ack = 1'b0; s_err = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (!s_cyc && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL %s: wbs_cyc_o got %b want 1 within 20 cycles", name, s_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc = '0; stb = '0; mask = 4'hF;
        s_ack = 1'b1; s_err = 1'b1;
        tick(); tick();
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", s_cyc); end
        checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", s_stb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", id); end
        checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL reset_tcnt: got %0d want 0", tcnt); end
        checks++; if (tid !== 2'd0) begin errors++; $display("FAIL reset_tid: got %0d want 0", tid); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        rst_n = 1'b1;
        tick();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL idle_ack_ignored: got %b want 0000", ack); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL idle_err_ignored: got %b want 0000", err); end
        s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        we  = 4'b0100;
        sel = {2'b10, 2'b01, 2'b11, 2'b00};
        adr = {16'h3333, 16'h1234, 16'h1111, 16'h0000};
        mdat_w = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        cyc[2] = 1'b1; stb[2] = 1'b1;
        wait_cyc("single_grant");
        checks++; if (s_adr !== 16'h1234) begin errors++; $display("FAIL single_adr: got %h want 1234", s_adr); end
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", id); end
        checks++; if (s_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", s_we); end
        checks++; if (s_sel !== 2'b01) begin errors++; $display("FAIL single_sel: got %b want 01", s_sel); end
        checks++; if (s_dat_w !== 16'hD002) begin errors++; $display("FAIL single_wdat: got %h want d002", s_dat_w); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b want 0000", ack); end
        tick();
        s_ack = 1'b1; s_dat_r = 16'hBEEF;
        #1;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL single_err: got %b want 0000", err); end
        checks++; if (mdat_r !== 16'hBEEF) begin errors++; $display("FAIL single_rdat: got %h want beef", mdat_r); end
        tick();
        s_ack = 1'b0;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_cyc_drop: got %b want 0", s_cyc); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_once: got %b want 0000", ack); end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_no_relatch: got %b want 0", s_cyc); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        cyc = 4'hF; stb = 4'hF;
        wait_cyc("rr_first");
        for (int k = 0; k < 8; k++) begin
            checks++; if (id !== 2'(k % 4)) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, id, k % 4); end
            s_ack = 1'b1;
            #1;
            checks++; if (ack !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ack, 4'(1 << (k % 4))); end
            tick();
            s_ack = 1'b0;
            checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_dead_cycle[%0d]: got %b want 0", k, s_cyc); end
            tick();
            checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL rr_next_grant[%0d]: got %b want 1", k, s_cyc); end
        end
    endtask

    task automatic test_mask();
        do_reset();
        mask = 4'b1011;
        cyc = 4'b1100; stb = 4'b1100;
        wait_cyc("mask_first");
        checks++; if (id !== 2'd3) begin errors++; $display("FAIL mask_first_id: got %0d want 3", id); end
        s_ack = 1'b1;
        #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL mask_first_ack: got %b want 1000", ack); end
        tick();
        s_ack = 1'b0; cyc[3] = 1'b0; stb[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", s_cyc); end
        end
        mask = 4'b1111;
        wait_cyc("mask_unmasked");
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL mask_second_id: got %0d want 2", id); end
        // master 0 posts a one-cycle request, then gets masked: it must stay pending
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        cyc[0] = 1'b0; stb[0] = 1'b0; mask = 4'b1110;
        s_ack = 1'b1;
        #1;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL mask_second_ack: got %b want 0100", ack); end
        tick();
        s_ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        wait_cyc("mask_kept_pending");
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL mask_kept_id: got %0d want 0", id); end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; mask = 4'hF;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1;
        wait_cyc("to_grant");
        repeat (14) tick();
        #1;
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL to_early_err: got %b want 0000 at cycle 15", err); end
        tick();
        #1;
        checks++; if (err !== 4'b0010) begin errors++; $display("FAIL to_err: got %b want 0010 at cycle 16", err); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL to_ack: got %b want 0000", ack); end
        tick();
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL to_cyc_drop: got %b want 0", s_cyc); end
        checks++; if (tcnt !== 8'd1) begin errors++; $display("FAIL to_cnt_1: got %0d want 1", tcnt); end
        checks++; if (tid !== 2'd1) begin errors++; $display("FAIL to_id_1: got %0d want 1", tid); end
        n = 1;
        for (int i = 0; i < 20000 && n < 300; i++) begin
            tick();
            #1;
            if (err[1]) n++;
        end
        checks++; if (n != 300) begin errors++; $display("FAIL to_abort_count: got %0d want 300 aborts", n); end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();
        checks++; if (tcnt !== 8'd255) begin errors++; $display("FAIL to_cnt_sat: got %0d want 255", tcnt); end
        checks++; if (tid !== 2'd1) begin errors++; $display("FAIL to_id_sat: got %0d want 1", tid); end
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1;
        wait_cyc("limit_grant");
        repeat (15) tick();
        s_ack = 1'b1;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL limit_ack: got %b want 0010", ack); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL limit_err: got %b want 0000", err); end
        tick();
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL limit_cnt: got %0d want 0", tcnt); end
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL limit_cyc_drop: got %b want 0", s_cyc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc = 4'b1001; stb = 4'b1001;
        wait_cyc("mid_first");
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL mid_first_id: got %0d want 0", id); end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        wait_cyc("mid_second");
        checks++; if (id !== 2'd3) begin errors++; $display("FAIL mid_second_id: got %0d want 3", id); end
        rst_n = 1'b0; cyc = '0; stb = '0;
        tick();
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL mid_cyc_drop: got %b want 0", s_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL mid_id: got %0d want 0", id); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL mid_pending_cleared: got %b want 0", s_cyc); end
        end
        cyc = 4'b1001; stb = 4'b1001;
        wait_cyc("mid_after");
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL mid_after_id: got %0d want 0", id); end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; cyc = '0; stb = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; mask = 4'hF; sel = '0;
        adr = '0; mdat_w = '0; s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

endmodule
